// File: rtl/dly_tap_cal_pkg.sv
// Shared state encoding and sizing helper for the delay-tap calibration controller.
package dly_tap_cal_pkg;

  typedef enum logic [2:0] {
    IDLE, SETTLE, MEASURE, EVAL, VERIFY_SETTLE, VERIFY_MEAS, FINISH, TRACK
  } cal_state_t;

  function automatic int tmr_width(input int win_cyc, input int settle_cyc);
    return $clog2(((win_cyc > settle_cyc) ? win_cyc : settle_cyc) + 1);
  endfunction

endpackage

// File: rtl/dly_tap_cal_sync.sv
// Two-flop synchronizer for the divided ring-oscillator output plus a
// change detector that yields a one-cycle strobe per observed toggle.
module dly_tap_cal_sync
  import dly_tap_cal_pkg::*;
(
  input  logic clk,
  input  logic rn,
  input  logic osc_tog,
  output logic tog
);

  logic meta, sync, prev;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= osc_tog;
      sync <= meta;
      prev <= sync;
    end
  end

  assign tog = sync ^ prev;

endmodule

// File: rtl/dly_tap_cal_ctrl.sv
// Successive-approximation tap calibration for a ring-oscillator delay line.
// Optional continuous re-tracking after calibration: define DLY_TAP_CAL_TRACK_EN.
module dly_tap_cal_ctrl
  import dly_tap_cal_pkg::*;
#(
  parameter int TAP_W      = 4,
  parameter int CNT_W      = 12,
  parameter int WIN_CYC    = 256,
  parameter int SETTLE_CYC = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic [CNT_W-1:0] TARGET,
  input  logic             OSC_TOG,
  output logic             OSC_EN,
  output logic [TAP_W-1:0] TAP_SEL,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [CNT_W-1:0] LAST_CNT
);

  localparam int TMR_W = tmr_width(WIN_CYC, SETTLE_CYC);
  localparam int K_W   = (TAP_W > 1) ? $clog2(TAP_W) : 1;
  localparam logic [TMR_W-1:0] SETTLE_END = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WIN_END    = TMR_W'(WIN_CYC - 1);
  localparam logic [TAP_W-1:0] TAP_MSB    = TAP_W'(1) << (TAP_W - 1);
  localparam logic [K_W-1:0]   K_TOP      = K_W'(TAP_W - 1);

  cal_state_t       state;
  logic [CNT_W-1:0] tgt, cnt, cnt_sum;
  logic [TMR_W-1:0] tmr;
  logic [K_W-1:0]   k;
  logic [TAP_W-1:0] eval_code;
  logic             tog, win_pass;
`ifdef DLY_TAP_CAL_TRACK_EN
  logic             trk_settle, prev_pass;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != '1)) return c + CNT_W'(1);
    return c;
  endfunction

  dly_tap_cal_sync u_sync (
    .clk     (CLK),
    .rn      (RN),
    .osc_tog (OSC_TOG),
    .tog     (tog)
  );

  assign cnt_sum  = sat_inc(cnt, tog);
  assign win_pass = (cnt_sum >= tgt);

  // SAR step: resolve the bit under test, then tentatively set the next lower one.
  always_comb begin
    eval_code = TAP_SEL;
    if (LAST_CNT < tgt) eval_code[k] = 1'b0;
    if (k != '0) eval_code[k - K_W'(1)] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state    <= IDLE;
      OSC_EN   <= 1'b0;
      TAP_SEL  <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      FAIL     <= 1'b0;
      LAST_CNT <= '0;
      tgt      <= '0;
      cnt      <= '0;
      tmr      <= '0;
      k        <= '0;
`ifdef DLY_TAP_CAL_TRACK_EN
      trk_settle <= 1'b0;
      prev_pass  <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      if (START && (state == IDLE || state == TRACK)) begin
        tgt     <= TARGET;
        k       <= K_TOP;
        TAP_SEL <= TAP_MSB;
        OSC_EN  <= 1'b1;
        BUSY    <= 1'b1;
        FAIL    <= 1'b0;
        tmr     <= '0;
        state   <= SETTLE;
      end else begin
        case (state)
          IDLE: tmr <= '0;
          SETTLE, VERIFY_SETTLE: begin
            tmr <= tmr + TMR_W'(1);
            if (tmr == SETTLE_END) begin
              state <= (state == SETTLE) ? MEASURE : VERIFY_MEAS;
              tmr   <= '0;
              cnt   <= '0;
            end
          end
          MEASURE, VERIFY_MEAS: begin
            tmr <= tmr + TMR_W'(1);
            cnt <= cnt_sum;
            if (tmr == WIN_END) begin
              LAST_CNT <= cnt_sum;
              tmr      <= '0;
              if (state == MEASURE) begin
                state <= EVAL;
              end else begin
                // Result flags are registered together so FAIL is valid alongside DONE.
                state <= FINISH;
                FAIL  <= !win_pass;
                DONE  <= 1'b1;
                BUSY  <= 1'b0;
`ifndef DLY_TAP_CAL_TRACK_EN
                OSC_EN <= 1'b0;
`endif
              end
            end
          end
          EVAL: begin
            TAP_SEL <= eval_code;
            tmr     <= '0;
            if (k != '0) begin
              k     <= k - K_W'(1);
              state <= SETTLE;
            end else begin
              state <= VERIFY_SETTLE;
            end
          end
          FINISH: begin
            tmr <= '0;
            cnt <= '0;
`ifdef DLY_TAP_CAL_TRACK_EN
            state      <= TRACK;
            trk_settle <= 1'b0;
            prev_pass  <= !FAIL;
`else
            state <= IDLE;
`endif
          end
          TRACK: begin
`ifdef DLY_TAP_CAL_TRACK_EN
            tmr <= tmr + TMR_W'(1);
            if (trk_settle) begin
              if (tmr == SETTLE_END) begin
                trk_settle <= 1'b0;
                tmr        <= '0;
                cnt        <= '0;
              end
            end else begin
              cnt <= cnt_sum;
              if (tmr == WIN_END) begin
                LAST_CNT  <= cnt_sum;
                FAIL      <= !win_pass;
                prev_pass <= win_pass;
                tmr       <= '0;
                cnt       <= '0;
                // Step down on any failure; step up only after two passing windows in a row.
                if (!win_pass && (TAP_SEL != '0)) begin
                  TAP_SEL    <= TAP_SEL - TAP_W'(1);
                  trk_settle <= 1'b1;
                end else if (win_pass && prev_pass && (TAP_SEL != '1)) begin
                  TAP_SEL    <= TAP_SEL + TAP_W'(1);
                  trk_settle <= 1'b1;
                end
              end
            end
`else
            state <= IDLE;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dly_tap_cal_ctrl.sv
// Bench for dly_tap_cal_ctrl: directed and randomized calibrations against a
// per-tap toggle-count oscillator model; the track test needs DLY_TAP_CAL_TRACK_EN.
module tb_dly_tap_cal_ctrl;

  localparam int TAP_W = 4;
  localparam int CNT_W = 12;
  localparam int WIN   = 256;
  localparam int SET   = 8;
  localparam int P     = SET + WIN + 1;
  localparam int LAT   = (TAP_W + 1) * P + 1;
  localparam int NTAP  = 1 << TAP_W;
`ifdef DLY_TAP_CAL_TRACK_EN
  localparam int OSC_AFTER = 1;
`else
  localparam int OSC_AFTER = 0;
`endif

  logic             clk = 1'b0, rn = 1'b0, start = 1'b0, osc_tog = 1'b0;
  logic [CNT_W-1:0] target = '0;
  logic             osc_en, busy, done, fail;
  logic [TAP_W-1:0] tap_sel;
  logic [CNT_W-1:0] last_cnt;

  logic             sat_start = 1'b0, sat_tog = 1'b0;
  logic [5:0]       sat_target = '0;
  logic             sat_osc_en, sat_busy, sat_done, sat_fail;
  logic [TAP_W-1:0] sat_tap;
  logic [5:0]       sat_last;

  int ncmp = 0, nfail = 0;
  int cnt_tab [NTAP];
  int trial_tap [TAP_W+1];
  int exp_trials [TAP_W+1] = '{8, 12, 10, 9, 8};
  int tog_goal = 0, tog_done = 0;
  bit cont_en = 1'b0, sat_run = 1'b0;
  int rate_base = 0, rate_slope = 0, acc = 0;
  int lat, ndone, busy_gap, restart;

  always #5 clk = ~clk;

  dly_tap_cal_ctrl #(.TAP_W(TAP_W), .CNT_W(CNT_W), .WIN_CYC(WIN), .SETTLE_CYC(SET)) dut (
    .CLK(clk), .RN(rn), .START(start), .TARGET(target), .OSC_TOG(osc_tog),
    .OSC_EN(osc_en), .TAP_SEL(tap_sel), .BUSY(busy), .DONE(done), .FAIL(fail),
    .LAST_CNT(last_cnt)
  );

  dly_tap_cal_ctrl #(.TAP_W(TAP_W), .CNT_W(6), .WIN_CYC(WIN), .SETTLE_CYC(SET)) dut_sat (
    .CLK(clk), .RN(rn), .START(sat_start), .TARGET(sat_target), .OSC_TOG(sat_tog),
    .OSC_EN(sat_osc_en), .TAP_SEL(sat_tap), .BUSY(sat_busy), .DONE(sat_done),
    .FAIL(sat_fail), .LAST_CNT(sat_last)
  );

  function automatic int rate_of(input logic [TAP_W-1:0] t);
    int r;
    r = rate_base - rate_slope * int'(t);
    return (r < 0) ? 0 : r;
  endfunction

  // Oscillator model: either a requested burst of toggles, or a free-running rate per tap.
  always @(negedge clk) begin
    if (tog_done != tog_goal) begin
      osc_tog  <= ~osc_tog;
      tog_done <= tog_done + 1;
    end else if (cont_en) begin
      if (acc + rate_of(tap_sel) >= 256) begin
        acc     <= acc + rate_of(tap_sel) - 256;
        osc_tog <= ~osc_tog;
      end else begin
        acc <= acc + rate_of(tap_sel);
      end
    end
  end

  always @(negedge clk) if (sat_run) sat_tog <= ~sat_tog;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge (the START cycle); feeds cnt_tab[tap] toggles into every window.
  task automatic run_cal(input int tgt, input bit hold, input int ncyc);
    int w;
    target = CNT_W'(tgt);
    start = 1'b1;
    lat = 0; ndone = 0; busy_gap = 0; restart = 0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (cyc >= SET + 4 && (cyc - SET - 4) % P == 0) begin
        w = (cyc - SET - 4) / P;
        if (w <= TAP_W) begin
          trial_tap[w] = int'(tap_sel);
          tog_goal = tog_goal + cnt_tab[tap_sel];
        end
      end
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) lat = cyc + 1;
      end
      if (lat == 0 && busy !== 1'b1) busy_gap++;
      if (lat != 0 && restart == 0 && cyc >= lat && busy === 1'b1) restart = cyc;
    end
  endtask

  initial begin
    int tgt, d, exp_tap, nd, prev, step_bad, osc_bad;
    bit seen;

    repeat (3) @(negedge clk);
    check("rst_osc_en", 32'(osc_en), 0);
    check("rst_tap_sel", 32'(tap_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_last_cnt", 32'(last_cnt), 0);
    rn = 1'b1;
    @(negedge clk);

    // Monotonic model count = 100 - 5*tap, target 60: trials 8,12,10,9 then verify at 8.
    for (int t = 0; t < NTAP; t++) cnt_tab[t] = 100 - 5 * t;
    run_cal(60, 1'b0, LAT + 20);
    check("a_latency", 32'(lat), 32'(LAT));
    check("a_done_count", 32'(ndone), 1);
    check("a_busy_gap", 32'(busy_gap), 0);
    for (int i = 0; i <= TAP_W; i++)
      check($sformatf("a_trial%0d", i), 32'(trial_tap[i]), 32'(exp_trials[i]));
    check("a_tap_sel", 32'(tap_sel), 8);
    check("a_last_cnt", 32'(last_cnt), 60);
    check("a_fail", 32'(fail), 0);
    check("a_osc_en", 32'(osc_en), 32'(OSC_AFTER));

    run_cal(120, 1'b0, LAT + 20);
    check("b_tap_sel", 32'(tap_sel), 0);
    check("b_last_cnt", 32'(last_cnt), 100);
    check("b_fail", 32'(fail), 1);
    check("b_done_count", 32'(ndone), 1);

    // Abort during the third measurement window.
    run_cal(60, 1'b0, 2 * P + SET + 50);
    check("c_busy_mid", 32'(busy), 1);
    check("c_fail_cleared", 32'(fail), 0);
    rn = 1'b0;
    #1;
    check("c_rst_osc_en", 32'(osc_en), 0);
    check("c_rst_tap_sel", 32'(tap_sel), 0);
    check("c_rst_busy", 32'(busy), 0);
    check("c_rst_done", 32'(done), 0);
    check("c_rst_last_cnt", 32'(last_cnt), 0);
    @(negedge clk);
    rn = 1'b1;
    nd = 0;
    repeat (P + 40) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check("c_no_done", 32'(nd), 0);
    run_cal(60, 1'b0, LAT + 20);
    check("c_rerun_latency", 32'(lat), 32'(LAT));
    check("c_rerun_tap_sel", 32'(tap_sel), 8);
    check("c_rerun_last_cnt", 32'(last_cnt), 60);

    // START held high: one calibration, next run begins from the IDLE cycle after FINISH.
    run_cal(60, 1'b1, LAT + 3);
    check("d_done_count", 32'(ndone), 1);
    check("d_latency", 32'(lat), 32'(LAT));
    check("d_busy_gap", 32'(busy_gap), 0);
    check("d_restart_cycle", 32'(restart), 32'(LAT + 1));
    start = 1'b0;
    rn = 1'b0;
    @(negedge clk);
    rn = 1'b1;
    @(negedge clk);

    // Toggle every cycle into a 6-bit counter with TARGET=0.
    sat_run = 1'b1;
    sat_start = 1'b1;
    @(negedge clk);
    sat_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < LAT + 20 && !seen; c++) begin
      @(negedge clk);
      if (sat_done === 1'b1) seen = 1'b1;
    end
    check("e_done_seen", 32'(seen), 1);
    check("e_last_cnt_sat", 32'(sat_last), 63);
    check("e_tap_sel", 32'(sat_tap), 15);
    check("e_fail", 32'(sat_fail), 0);
    check("e_busy", 32'(sat_busy), 0);
    check("e_osc_en", 32'(sat_osc_en), 32'(OSC_AFTER));
    sat_run = 1'b0;

    // Random monotonic tables against a direct scan for the largest qualifying tap.
    for (int r = 0; r < 3; r++) begin
      cnt_tab[0] = int'($urandom_range(60, 230));
      for (int t = 1; t < NTAP; t++) begin
        d = int'($urandom_range(0, 15));
        cnt_tab[t] = (cnt_tab[t-1] > d) ? cnt_tab[t-1] - d : 0;
      end
      tgt = int'($urandom_range(0, 32'(cnt_tab[0] + 20)));
      exp_tap = 0;
      for (int t = 0; t < NTAP; t++) if (cnt_tab[t] >= tgt) exp_tap = t;
      run_cal(tgt, 1'b0, LAT + 20);
      check($sformatf("r%0d_tap_sel", r), 32'(tap_sel), 32'(exp_tap));
      check($sformatf("r%0d_last_cnt", r), 32'(last_cnt), 32'(cnt_tab[exp_tap]));
      check($sformatf("r%0d_fail", r), 32'(fail), 32'(cnt_tab[exp_tap] < tgt));
      check($sformatf("r%0d_done_count", r), 32'(ndone), 1);
    end

`ifdef DLY_TAP_CAL_TRACK_EN
    // Free-running oscillator: calibrate to 8, then slow it so only taps <= 6 pass.
    rate_base = 150; rate_slope = 10; cont_en = 1'b1;
    target = CNT_W'(65);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < LAT + 20 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("t_cal_done", 32'(seen), 1);
    check("t_cal_tap", 32'(tap_sel), 8);
    rate_base = 130;
    prev = int'(tap_sel); step_bad = 0; osc_bad = 0; seen = 1'b0;
    for (int c = 0; c < 4 * P + 100 && !seen; c++) begin
      @(negedge clk);
      if (osc_en !== 1'b1) osc_bad++;
      if (int'(tap_sel) != prev) begin
        if (int'(tap_sel) != prev - 1) step_bad++;
        prev = int'(tap_sel);
      end
      if (tap_sel == 6) seen = 1'b1;
    end
    check("t_reached_6", 32'(seen), 1);
    check("t_single_steps", 32'(step_bad), 0);
    check("t_osc_en_held", 32'(osc_bad), 0);
    cont_en = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
